// File: rtl/entry_pkg.sv
// Shared state codes, operator codes and operator legality rule for entry_sequencer.
package entry_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_WAIT = 3'd4,
    S_SHOW = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_MAX = OP_OR;

  function automatic logic op_legal(input logic [7:0] code);
    return (code[7:3] == 5'd0) && (code[2:0] <= OP_MAX);
  endfunction

endpackage

// File: rtl/entry_timer.sv
// Idle-entry watchdog: counts enabled cycles and flags the last one before expiry.
module entry_timer #(
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int TO_W           = 29
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + TO_W'(1);
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/entry_sequencer.sv
// Sequences A / operator / B entry into the shared ALU and holds the result.
// Optional idle-entry timeout is built when ENTRY_TIMEOUT_EN is defined.
module entry_sequencer
  import entry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int TO_W           = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        clear,
  output logic        alu_start,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_err,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        err,
  output logic        timeout,
  output logic [2:0]  stage,
  output logic        busy
);

  state_t state;
  logic   clear_pend;
  logic   expired;

  assign stage = state;

`ifdef ENTRY_TIMEOUT_EN
  logic timer_en;
  logic timer_clr;

  // Outside S_OP/S_B the counter is held at zero, so every entry into them starts fresh.
  assign timer_en  = (state == S_OP) || (state == S_B);
  assign timer_clr = in_valid | clear | ~timer_en | expired;

  entry_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0) ^ (TO_W > 0);
  assign expired    = 1'b0;
`endif

  // Priority: clear (where it acts immediately) > in_valid > timeout expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_A;
      clear_pend   <= 1'b0;
      alu_start    <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      timeout   <= 1'b0;
      if (clear && (state == S_A || state == S_OP || state == S_B || state == S_SHOW)) begin
        state        <= S_A;
        alu_a        <= '0;
        alu_b        <= '0;
        alu_op       <= '0;
        result       <= '0;
        result_valid <= 1'b0;
        err          <= 1'b0;
      end else begin
        case (state)
          S_A: if (in_valid) begin
            alu_a <= in_data;
            err   <= 1'b0;
            state <= S_OP;
          end
          S_OP: if (in_valid) begin
            if (op_legal(in_data)) begin
              alu_op <= in_data[2:0];
              err    <= 1'b0;
              state  <= S_B;
            end else begin
              err <= 1'b1;
            end
          end else if (expired) begin
            timeout <= 1'b1;
            err     <= 1'b1;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            state   <= S_A;
          end
          S_B: if (in_valid) begin
            alu_b     <= in_data;
            alu_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_EXEC;
          end else if (expired) begin
            timeout <= 1'b1;
            err     <= 1'b1;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            state   <= S_A;
          end
          S_EXEC: begin
            if (clear) clear_pend <= 1'b1;
            state <= S_WAIT;
          end
          S_WAIT: if (alu_done) begin
            busy       <= 1'b0;
            clear_pend <= 1'b0;
            if (clear_pend || clear) begin
              alu_a        <= '0;
              alu_b        <= '0;
              alu_op       <= '0;
              result       <= '0;
              result_valid <= 1'b0;
              err          <= 1'b0;
              state        <= S_A;
            end else begin
              result       <= alu_result;
              err          <= alu_err;
              result_valid <= 1'b1;
              state        <= S_SHOW;
            end
          end else if (clear) begin
            clear_pend <= 1'b1;
          end
          S_SHOW: if (in_valid) begin
            alu_a        <= in_data;
            result_valid <= 1'b0;
            err          <= 1'b0;
            state        <= S_OP;
          end
          default: state <= S_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_entry_sequencer.sv
// Self-checking bench for entry_sequencer: directed scenarios plus randomized transactions
// checked against a transaction-level ALU/entry model.
module tb_entry_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clear;
  logic        alu_start;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_err;
  logic [15:0] result;
  logic        result_valid;
  logic        err;
  logic        timeout;
  logic [2:0]  stage;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int tpulses = 0;

  entry_sequencer #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .result(result), .result_valid(result_valid), .err(err), .timeout(timeout),
    .stage(stage), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (alu_start === 1'b1) starts++;
    if (timeout === 1'b1) tpulses++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic alu_finish(input logic [15:0] r, input logic e);
    alu_done   = 1'b1;
    alu_result = r;
    alu_err    = e;
    @(negedge clk);
    alu_done   = 1'b0;
    alu_result = 16'($urandom);
    alu_err    = 1'($urandom);
  endtask

  // Reference ALU arithmetic; divide by zero reports an error with a zero result.
  function automatic void alu_model(input logic [7:0] a, input logic [2:0] op,
                                    input logic [7:0] b, output logic [15:0] r,
                                    output logic e);
    e = 1'b0;
    case (op)
      3'd0: r = {8'h00, a} + {8'h00, b};
      3'd1: r = {8'h00, a} - {8'h00, b};
      3'd2: r = 16'(a) * 16'(b);
      3'd3: if (b == 8'h00) begin r = 16'h0000; e = 1'b1; end else r = {8'h00, a / b};
      3'd4: r = {8'h00, a & b};
      3'd5: r = {8'h00, a | b};
      default: r = 16'h0000;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0;
    alu_done = 1'b0; alu_result = 16'h0000; alu_err = 1'b0;
    repeat (2) step();
    checks++;
    if ({stage, alu_a, alu_b, alu_op, result, result_valid, err, timeout, busy, alu_start} !== 48'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: stage=%0d a=%h b=%h op=%0d res=%h rv=%b err=%b to=%b busy=%b start=%b, want all zero",
               stage, alu_a, alu_b, alu_op, result, result_valid, err, timeout, busy, alu_start);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int s0;
    pulse(8'h12);
    checks++; if (stage !== 3'd1 || alu_a !== 8'h12) begin errors++; $display("[TB] FAIL basic_a: stage=%0d a=%h, want 1 12", stage, alu_a); end
    pulse(8'h00);
    checks++; if (stage !== 3'd2 || alu_op !== 3'd0) begin errors++; $display("[TB] FAIL basic_op: stage=%0d op=%0d, want 2 0", stage, alu_op); end
    s0 = starts;
    pulse(8'h34);
    checks++; if (alu_start !== 1'b1 || stage !== 3'd3 || busy !== 1'b1 || alu_b !== 8'h34) begin
      errors++; $display("[TB] FAIL basic_start: start=%b stage=%0d busy=%b b=%h, want 1 3 1 34", alu_start, stage, busy, alu_b);
    end
    repeat (3) step();
    alu_finish(16'h0046, 1'b0);
    checks++; if (result !== 16'h0046 || result_valid !== 1'b1 || stage !== 3'd5 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_result: res=%h rv=%b stage=%0d busy=%b err=%b, want 0046 1 5 0 0", result, result_valid, stage, busy, err);
    end
    checks++; if (starts !== s0 + 1) begin errors++; $display("[TB] FAIL basic_start_count: got %0d want %0d", starts - s0, 1); end
  endtask

  task automatic test_illegal_op();
    pulse(8'h20);
    checks++; if (stage !== 3'd1 || result_valid !== 1'b0 || alu_a !== 8'h20) begin
      errors++; $display("[TB] FAIL chain_from_show: stage=%0d rv=%b a=%h, want 1 0 20", stage, result_valid, alu_a);
    end
    pulse(8'h0F);
    checks++; if (err !== 1'b1 || stage !== 3'd1) begin errors++; $display("[TB] FAIL illegal_op: err=%b stage=%0d, want 1 1", err, stage); end
    pulse(8'h03);
    checks++; if (err !== 1'b0 || alu_op !== 3'd3 || stage !== 3'd2) begin
      errors++; $display("[TB] FAIL legal_after_illegal: err=%b op=%0d stage=%0d, want 0 3 2", err, alu_op, stage);
    end
    pulse(8'h00);
    step();
    alu_finish(16'h0000, 1'b1);
    checks++; if (err !== 1'b1 || result_valid !== 1'b1 || stage !== 3'd5) begin
      errors++; $display("[TB] FAIL alu_err: err=%b rv=%b stage=%0d, want 1 1 5", err, result_valid, stage);
    end
  endtask

  task automatic test_clear_wait();
    pulse(8'h07); pulse(8'h02); pulse(8'h09);
    step();
    pulse_clear();
    checks++; if (stage !== 3'd4 || busy !== 1'b1) begin errors++; $display("[TB] FAIL clear_pending_hold: stage=%0d busy=%b, want 4 1", stage, busy); end
    pulse(8'h55);
    checks++; if (stage !== 3'd4 || alu_a !== 8'h07) begin errors++; $display("[TB] FAIL ignore_in_wait: stage=%0d a=%h, want 4 07", stage, alu_a); end
    alu_finish(16'h003F, 1'b0);
    checks++; if (stage !== 3'd0 || result_valid !== 1'b0 || result !== 16'h0000 || alu_a !== 8'h00 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_discard: stage=%0d rv=%b res=%h a=%h err=%b busy=%b, want 0 0 0000 00 0 0",
                         stage, result_valid, result, alu_a, err, busy);
    end
  endtask

  task automatic test_chain();
    pulse(8'h03); pulse(8'h01); pulse(8'h05);
    step();
    alu_finish(16'hFFFE, 1'b0);
    pulse(8'h05);
    checks++; if (alu_a !== 8'h05 || result_valid !== 1'b0 || stage !== 3'd1 || result !== 16'hFFFE) begin
      errors++; $display("[TB] FAIL chain_entry: a=%h rv=%b stage=%0d res=%h, want 05 0 1 fffe", alu_a, result_valid, stage, result);
    end
    pulse(8'h04); pulse(8'h0C);
    step();
    alu_finish(16'h0004, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    step();
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (stage !== 3'd0 || alu_a !== 8'h00 || result_valid !== 1'b0 || result !== 16'h0000) begin
      errors++; $display("[TB] FAIL clear_beats_valid: stage=%0d a=%h rv=%b res=%h, want 0 00 0 0000", stage, alu_a, result_valid, result);
    end
  endtask

  task automatic test_reset_abort();
    pulse(8'h01); pulse(8'h00); pulse(8'h02);
    step();
    rst = 1'b1;
    #1;
    checks++; if (stage !== 3'd0 || busy !== 1'b0 || alu_a !== 8'h00) begin
      errors++; $display("[TB] FAIL async_reset: stage=%0d busy=%b a=%h, want 0 0 00", stage, busy, alu_a);
    end
    step();
    rst = 1'b0;
    step();
    alu_finish(16'h1234, 1'b0);
    checks++; if (stage !== 3'd0 || result_valid !== 1'b0 || result !== 16'h0000) begin
      errors++; $display("[TB] FAIL done_after_reset: stage=%0d rv=%b res=%h, want 0 0 0000", stage, result_valid, result);
    end
  endtask

  task automatic test_random();
    logic [7:0]  a, b, bad;
    logic [2:0]  op;
    logic [15:0] r;
    logic        e, clr_mid;
    int          lat, s0;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 5) == 0) b = 8'h00;
      lat = $urandom_range(1, 4);
      clr_mid = ($urandom_range(0, 4) == 0);
      alu_model(a, op, b, r, e);
      pulse(a);
      checks++; if (stage !== 3'd1 || alu_a !== a || result_valid !== 1'b0 || err !== 1'b0) begin
        errors++; $display("[TB] FAIL rnd%0d_a: stage=%0d a=%h rv=%b err=%b, want 1 %h 0 0", i, stage, alu_a, result_valid, err, a);
      end
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) bad = {5'($urandom_range(1, 31)), 3'($urandom_range(0, 7))};
        else bad = {5'd0, 3'($urandom_range(6, 7))};
        pulse(bad);
        checks++; if (stage !== 3'd1 || err !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_illegal: stage=%0d err=%b, want 1 1", i, stage, err); end
      end
      pulse({5'd0, op});
      checks++; if (stage !== 3'd2 || alu_op !== op || err !== 1'b0) begin
        errors++; $display("[TB] FAIL rnd%0d_op: stage=%0d op=%0d err=%b, want 2 %0d 0", i, stage, alu_op, err, op);
      end
      s0 = starts;
      pulse(b);
      checks++; if (alu_start !== 1'b1 || stage !== 3'd3 || alu_b !== b || busy !== 1'b1) begin
        errors++; $display("[TB] FAIL rnd%0d_start: start=%b stage=%0d b=%h busy=%b, want 1 3 %h 1", i, alu_start, stage, alu_b, busy, b);
      end
      for (int k = 0; k < lat; k++) begin
        if (clr_mid && k == 0) clear = 1'b1;
        step();
        clear = 1'b0;
      end
      checks++; if (stage !== 3'd4 || busy !== 1'b1 || alu_start !== 1'b0 || starts !== s0 + 1) begin
        errors++; $display("[TB] FAIL rnd%0d_wait: stage=%0d busy=%b start=%b starts=%0d, want 4 1 0 1", i, stage, busy, alu_start, starts - s0);
      end
      alu_finish(r, e);
      if (clr_mid) begin
        checks++; if (stage !== 3'd0 || result_valid !== 1'b0 || result !== 16'h0000 || err !== 1'b0 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'd0) begin
          errors++; $display("[TB] FAIL rnd%0d_cleared: stage=%0d rv=%b res=%h err=%b a=%h b=%h op=%0d, want all zero",
                             i, stage, result_valid, result, err, alu_a, alu_b, alu_op);
        end
      end else begin
        checks++; if (stage !== 3'd5 || result_valid !== 1'b1 || result !== r || err !== e || busy !== 1'b0) begin
          errors++; $display("[TB] FAIL rnd%0d_result: stage=%0d rv=%b res=%h err=%b busy=%b, want 5 1 %h %b 0",
                             i, stage, result_valid, result, err, busy, r, e);
        end
      end
    end
  endtask

`ifdef ENTRY_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    pulse_clear();
    t0 = tpulses;
    pulse(8'h11);
    repeat (15) step();
    checks++; if (timeout !== 1'b0 || stage !== 3'd1) begin errors++; $display("[TB] FAIL timeout_early: to=%b stage=%0d, want 0 1", timeout, stage); end
    step();
    checks++; if (timeout !== 1'b1 || err !== 1'b1 || stage !== 3'd0 || alu_a !== 8'h00) begin
      errors++; $display("[TB] FAIL timeout_fire: to=%b err=%b stage=%0d a=%h, want 1 1 0 00", timeout, err, stage, alu_a);
    end
    step();
    checks++; if (timeout !== 1'b0 || tpulses !== t0 + 1) begin
      errors++; $display("[TB] FAIL timeout_pulse: to=%b pulses=%0d, want 0 1", timeout, tpulses - t0);
    end
    t0 = tpulses;
    pulse(8'h22);
    repeat (15) step();
    pulse(8'h01);
    checks++; if (stage !== 3'd2 || err !== 1'b0 || alu_op !== 3'd1 || tpulses !== t0) begin
      errors++; $display("[TB] FAIL timeout_valid_wins: stage=%0d err=%b op=%0d pulses=%0d, want 2 0 1 0", stage, err, alu_op, tpulses - t0);
    end
    pulse_clear();
  endtask
`else
  task automatic test_timeout();
    int t0;
    pulse_clear();
    t0 = tpulses;
    pulse(8'h11);
    repeat (40) step();
    checks++; if (stage !== 3'd1 || timeout !== 1'b0 || err !== 1'b0 || tpulses !== t0) begin
      errors++; $display("[TB] FAIL no_timeout: stage=%0d to=%b err=%b pulses=%0d, want 1 0 0 0", stage, timeout, err, tpulses - t0);
    end
    pulse_clear();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_illegal_op();
    test_clear_wait();
    test_chain();
    test_reset_abort();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/entry_sequencer.md
# entry_sequencer

- Sequences operand and operator entry from the debounced switch/button front end into a shared 8-bit ALU.
- Front-end capture pulses are consumed in order: operand A, operator, operand B.
- The block then issues one ALU start, waits for completion, and holds the result for the display path.
- It sits between the button front end and the ALU/seven-segment logic, and is the only master of the ALU handshake.

## Interface

Parameters:
- TIMEOUT_CYCLES, 500_000_000, idle cycles allowed in S_OP/S_B before entry is abandoned (5 s at 100 MHz).
- TO_W, 29, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  one-cycle capture pulse from the front end.
- in_data  in  8  switch value captured with in_valid.
- clear  in  1  one-cycle abort pulse from a second front-end button.
- alu_start  out  1  one-cycle ALU start.
- alu_a  out  8  operand A, held.
- alu_b  out  8  operand B, held.
- alu_op  out  3  operator code, held.
- alu_done  in  1  one-cycle ALU completion.
- alu_result  in  16  ALU result, valid with alu_done.
- alu_err  in  1  ALU error flag (e.g. divide by zero), valid with alu_done.
- result  out  16  captured result, held.
- result_valid  out  1  level; result is current.
- err  out  1  level; illegal operator, ALU error, or timeout.
- timeout  out  1  one-cycle pulse on entry timeout.
- stage  out  3  current state code, used for the display prompt.
- busy  out  1  high in S_EXEC and S_WAIT.

## Operation

- States and codes: S_A=0, S_OP=1, S_B=2, S_EXEC=3, S_WAIT=4, S_SHOW=5.
- Reset values:
  - state is S_A.
  - All outputs are 0.
- S_A: on in_valid, alu_a <= in_data, err <= 0, then go to S_OP.
- S_OP: on in_valid, the operator is legal only when in_data[7:3]==0 and in_data[2:0]<=5.
  - Operator codes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR.
  - Legal: alu_op <= in_data[2:0], err <= 0, then go to S_B.
  - Illegal: err <= 1 and stay in S_OP.
- S_B: on in_valid, alu_b <= in_data, then go to S_EXEC.
- S_EXEC: alu_start = 1 for exactly this cycle, then go to S_WAIT unconditionally.
- S_WAIT: on alu_done, result <= alu_result, err <= alu_err, result_valid <= 1, then go to S_SHOW.
- S_SHOW: result and result_valid are held.
  - in_valid starts a chained entry: alu_a <= in_data, result_valid <= 0, err <= 0, then go to S_OP.
- in_valid is ignored in S_EXEC and S_WAIT.
- alu_done is ignored outside S_WAIT.
- clear behaviour:
  - In S_A, S_OP, S_B or S_SHOW: go to S_A and zero alu_a, alu_b, alu_op, result, result_valid and err.
  - In S_EXEC or S_WAIT: set a pending flag. On alu_done, discard the result and perform the clear.
- clear and in_valid in the same cycle: clear wins and the entry is dropped.

## Timing

- in_valid in cycle n updates the captured register and stage in cycle n+1.
- Operand B entry at cycle n:
  - alu_start is high in cycle n+1.
  - The earliest sampled alu_done is in cycle n+2.
- alu_done in cycle m: result, result_valid and stage=5 are visible in cycle m+1.
- alu_start never asserts twice without an intervening alu_done.
- rst mid-operation aborts immediately. A later alu_done arriving in S_A is ignored.

## Configuration

- ENTRY_TIMEOUT_EN defined:
  - The counter clears on every in_valid and on every state change.
  - The counter increments each cycle in S_OP and S_B.
  - On reaching TIMEOUT_CYCLES-1: timeout pulses for one cycle, err <= 1, alu_a, alu_b and alu_op are zeroed, and state goes to S_A.
  - in_valid in that same cycle wins: it is accepted and no timeout occurs.
- ENTRY_TIMEOUT_EN undefined:
  - No counter is built.
  - timeout is tied to 0.
  - S_OP and S_B wait indefinitely.

## Structure

- Shared package entry_pkg holds:
  - state codes S_A to S_SHOW (3-bit localparams);
  - operator codes OP_ADD to OP_OR;
  - OP_MAX=5.
- One sub-module, entry_timer:
  - Ports: clk, rst, clr, en, expired.
  - Parameterised by TIMEOUT_CYCLES and TO_W.
  - Instantiated only under ENTRY_TIMEOUT_EN.
- The FSM and capture registers live in entry_sequencer.

## Test plan

- Pulses 0x12, 0x00, 0x34; ALU returns 0x0046 three cycles after start -> one alu_start, alu_a=0x12, alu_op=0, alu_b=0x34, result=0x0046, result_valid=1, stage=5.
- Operator 0x0F in S_OP -> err=1, stage stays 1; then 0x03 -> err=0, alu_op=3, stage=2.
- alu_err=1 with alu_done (divide 0x20 by 0x00) -> err=1, result_valid=1, stage=5.
- clear during S_WAIT, then alu_done -> result discarded, stage=0, result_valid=0; in_valid during S_WAIT -> no effect.
- In S_SHOW, in_valid 0x05 -> alu_a=0x05, result_valid=0, stage=1; clear and in_valid in the same cycle -> stage=0.
- With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16: enter A, idle 16 cycles -> timeout pulse, err=1, stage=0; an in_valid on the expiry cycle -> accepted, no timeout.
